// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked Hack ALU with iterative unsigned multiply and restoring divide
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [1:0]       mode,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rem,
    output logic             zr,
    output logic             ng,
    output logic             dz
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    step;
    logic             is_div;
    logic [WIDTH-1:0] opa;   // MUL: multiplicand shifted left; DIV: dividend turning into quotient
    logic [WIDTH-1:0] opb;   // MUL: multiplier shifted right; DIV: divisor, held
    logic [WIDTH-1:0] acc;   // MUL: partial product; DIV: partial remainder

    logic             is_long;
    logic             last;
    logic [WIDTH-1:0] hx_z, hx, hy_z, hy, hr, hack_res;
    logic [WIDTH-1:0] mul_acc_nxt;
    logic [WIDTH:0]   div_trial, div_rem_full;
    logic             div_ge;
    logic [WIDTH-1:0] div_q_nxt;
    logic [WIDTH-1:0] long_out, long_rem;

    assign is_long = (mode == 2'b01) || (mode == 2'b10);
    assign last    = (step == CW'(WIDTH - 1));

    // Single-pass Hack function on the live operands, plus one multiply/divide step on the held ones
    always_comb begin
        hx_z     = zx ? '0 : x;
        hx       = nx ? ~hx_z : hx_z;
        hy_z     = zy ? '0 : y;
        hy       = ny ? ~hy_z : hy_z;
        hr       = f ? (hx + hy) : (hx & hy);
        hack_res = no ? ~hr : hr;

        mul_acc_nxt = acc + (opb[0] ? opa : '0);

        // A zero divisor always passes the compare, which yields all-ones quotient and rem = x
        div_trial    = {acc, opa[WIDTH-1]};
        div_ge       = (div_trial >= {1'b0, opb});
        div_rem_full = div_ge ? (div_trial - {1'b0, opb}) : div_trial;
        div_q_nxt    = {opa[WIDTH-2:0], div_ge};

        long_out = is_div ? div_q_nxt : mul_acc_nxt;
        long_rem = is_div ? div_rem_full[WIDTH-1:0] : '0;
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = is_long ? BUSY : DONE;
            end
            BUSY: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and registered result/flags
    always_ff @(posedge clock) begin
        if (reset) begin
            step   <= '0;
            is_div <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            out    <= '0;
            rem    <= '0;
            zr     <= 1'b0;
            ng     <= 1'b0;
            dz     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        step   <= '0;
                        is_div <= (mode == 2'b10);
                        opa    <= x;
                        opb    <= y;
                        acc    <= '0;
                        if (!is_long) begin
                            out <= hack_res;
                            rem <= '0;
                            zr  <= (hack_res == '0);
                            ng  <= hack_res[WIDTH-1];
                            dz  <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    step <= step + 1'b1;
                    if (is_div) begin
                        opa <= div_q_nxt;
                        acc <= div_rem_full[WIDTH-1:0];
                    end else begin
                        opa <= opa << 1;
                        opb <= opb >> 1;
                        acc <= mul_acc_nxt;
                    end
                    if (last) begin
                        out <= long_out;
                        rem <= long_rem;
                        zr  <= (long_out == '0);
                        ng  <= long_out[WIDTH-1];
                        dz  <= is_div && (opb == '0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
